// File: rtl/d_mem_arbiter_if.sv
// Bus bundle for d_mem_arbiter: two requester ports plus the memory side.
// The arbiter connects through the slave modport; the environment
// (requesters and memory model) uses the master modport.
interface d_mem_arbiter_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
);
  // Requester 0
  logic                    r0_load;
  logic                    r0_store;
  logic [ADDRESS_BITS-1:0] r0_address;
  logic [DATA_WIDTH-1:0]   r0_store_data;
  logic                    r0_ready;
  logic                    r0_valid;
  logic [DATA_WIDTH-1:0]   r0_load_data;
  logic [ADDRESS_BITS-1:0] r0_data_addr;

  // Requester 1
  logic                    r1_load;
  logic                    r1_store;
  logic [ADDRESS_BITS-1:0] r1_address;
  logic [DATA_WIDTH-1:0]   r1_store_data;
  logic                    r1_ready;
  logic                    r1_valid;
  logic [DATA_WIDTH-1:0]   r1_load_data;
  logic [ADDRESS_BITS-1:0] r1_data_addr;

  // Memory side
  logic [ADDRESS_BITS-1:0] d_mem_address;
  logic [DATA_WIDTH-1:0]   d_mem_in_data;
  logic                    d_mem_read;
  logic                    d_mem_write;
  logic [ADDRESS_BITS-1:0] d_mem_out_addr;
  logic [DATA_WIDTH-1:0]   d_mem_out_data;
  logic                    d_mem_valid;
  logic                    d_mem_ready;

  modport slave (
    input  r0_load, r0_store, r0_address, r0_store_data,
    output r0_ready, r0_valid, r0_load_data, r0_data_addr,
    input  r1_load, r1_store, r1_address, r1_store_data,
    output r1_ready, r1_valid, r1_load_data, r1_data_addr,
    output d_mem_address, d_mem_in_data, d_mem_read, d_mem_write,
    input  d_mem_out_addr, d_mem_out_data, d_mem_valid, d_mem_ready
  );

  modport master (
    output r0_load, r0_store, r0_address, r0_store_data,
    input  r0_ready, r0_valid, r0_load_data, r0_data_addr,
    output r1_load, r1_store, r1_address, r1_store_data,
    input  r1_ready, r1_valid, r1_load_data, r1_data_addr,
    input  d_mem_address, d_mem_in_data, d_mem_read, d_mem_write,
    output d_mem_out_addr, d_mem_out_data, d_mem_valid, d_mem_ready
  );
endinterface

// File: rtl/d_mem_arbiter.sv
// Two-requester data-memory arbiter with a single outstanding operation.
// IDLE samples requests and latches the winner's command, ISSUE presents it
// to memory until d_mem_ready, WAIT_RESP returns load data to the owner.
// Optional macro D_MEM_ARB_ROUND_ROBIN_EN: round-robin resolution of
// simultaneous requests; when undefined requester 0 has fixed priority.
module d_mem_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20,
  parameter int CORE         = 0
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           report,
  d_mem_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ISSUE     = 2'd1;
  localparam logic [1:0] WAIT_RESP = 2'd2;

  logic [1:0]              state;
  logic                    owner;
  logic                    cmd_load;
  logic [ADDRESS_BITS-1:0] cmd_address;
  logic [DATA_WIDTH-1:0]   cmd_data;
  logic [31:0]             cycle_count;

  logic                    r0_ready_q;
  logic                    r1_ready_q;
  logic                    r0_valid_q;
  logic                    r1_valid_q;
  logic [DATA_WIDTH-1:0]   r0_load_data_q;
  logic [DATA_WIDTH-1:0]   r1_load_data_q;
  logic [ADDRESS_BITS-1:0] r0_data_addr_q;
  logic [ADDRESS_BITS-1:0] r1_data_addr_q;

  logic                    req0;
  logic                    req1;
  logic                    win1;
  logic                    any_req;

  assign req0    = bus.r0_load | bus.r0_store;
  assign req1    = bus.r1_load | bus.r1_store;
  assign any_req = req0 | req1;

`ifdef D_MEM_ARB_ROUND_ROBIN_EN
  logic rr_ptr;

  // Round-robin pointer: after every grant it points at the other requester
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr <= 1'b0;
    end else if (state == IDLE && any_req) begin
      rr_ptr <= ~win1;
    end
  end

  // Winner select: a lone requester wins, a tie goes to the pointer
  always_comb begin
    win1 = req1 & (~req0 | rr_ptr);
  end
`else
  // Winner select: a lone requester wins, a tie goes to requester 0
  always_comb begin
    win1 = req1 & ~req0;
  end
`endif

  // Main FSM: arbitration, command latch, response routing
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      owner          <= 1'b0;
      cmd_load       <= 1'b0;
      cmd_address    <= '0;
      cmd_data       <= '0;
      r0_ready_q     <= 1'b0;
      r1_ready_q     <= 1'b0;
      r0_valid_q     <= 1'b0;
      r1_valid_q     <= 1'b0;
      r0_load_data_q <= '0;
      r1_load_data_q <= '0;
      r0_data_addr_q <= '0;
      r1_data_addr_q <= '0;
    end else begin
      r0_ready_q <= 1'b0;
      r1_ready_q <= 1'b0;
      r0_valid_q <= 1'b0;
      r1_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner <= win1;
            if (win1) begin
              // load wins over store when both are raised together
              cmd_load    <= bus.r1_load;
              cmd_address <= bus.r1_address;
              cmd_data    <= bus.r1_store_data;
              r1_ready_q  <= 1'b1;
            end else begin
              cmd_load    <= bus.r0_load;
              cmd_address <= bus.r0_address;
              cmd_data    <= bus.r0_store_data;
              r0_ready_q  <= 1'b1;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.d_mem_ready) begin
            state <= cmd_load ? WAIT_RESP : IDLE;
          end
        end
        WAIT_RESP: begin
          if (bus.d_mem_valid) begin
            if (owner) begin
              r1_load_data_q <= bus.d_mem_out_data;
              r1_data_addr_q <= bus.d_mem_out_addr;
              r1_valid_q     <= 1'b1;
            end else begin
              r0_load_data_q <= bus.d_mem_out_data;
              r0_data_addr_q <= bus.d_mem_out_addr;
              r0_valid_q     <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Free-running cycle counter used by the report trace
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycle_count <= '0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
    end
  end

  // Memory command is decoded from state so read/write are low outside ISSUE
  assign bus.d_mem_read    = (state == ISSUE) &&  cmd_load;
  assign bus.d_mem_write   = (state == ISSUE) && !cmd_load;
  assign bus.d_mem_address = cmd_address;
  assign bus.d_mem_in_data = cmd_data;

  assign bus.r0_ready     = r0_ready_q;
  assign bus.r1_ready     = r1_ready_q;
  assign bus.r0_valid     = r0_valid_q;
  assign bus.r1_valid     = r1_valid_q;
  assign bus.r0_load_data = r0_load_data_q;
  assign bus.r1_load_data = r1_load_data_q;
  assign bus.r0_data_addr = r0_data_addr_q;
  assign bus.r1_data_addr = r1_data_addr_q;

`ifndef SYNTHESIS
  function automatic string state_name(input logic [1:0] s);
    case (s)
      IDLE:      return "IDLE";
      ISSUE:     return "ISSUE";
      WAIT_RESP: return "WAIT_RESP";
      default:   return "UNKNOWN";
    endcase
  endfunction

  // Debug trace of cycle, state, grant and memory command on request
  always_ff @(posedge clock) begin
    if (report) begin
      $display("d_mem_arbiter core %0d cycle %0d state %s grant %0d read %0b write %0b addr %h data %h",
               CORE, cycle_count, state_name(state), owner,
               bus.d_mem_read, bus.d_mem_write, bus.d_mem_address, bus.d_mem_in_data);
    end
  end
`endif

endmodule

// File: tb/tb_d_mem_arbiter.sv
// Self-checking bench for d_mem_arbiter: directed scenarios followed by
// randomized transactions, checked against a transaction-level model of
// the grant policy and per-requester response registers.
module tb_d_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 20;
`ifdef D_MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clock;
  logic reset;
  logic report;

  d_mem_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_BITS(AW)) bus ();

  d_mem_arbiter #(.DATA_WIDTH(DW), .ADDRESS_BITS(AW), .CORE(0)) dut (
    .clock  (clock),
    .reset  (reset),
    .report (report),
    .bus    (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks;
  int failures;

  // Reference model: preferred requester for ties and last responses
  int            pref;
  logic [DW-1:0] m_ld [2];
  logic [AW-1:0] m_da [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pref = 0;
    m_ld[0] = '0; m_ld[1] = '0;
    m_da[0] = '0; m_da[1] = '0;
  endtask

  task automatic check_responses(input string tag);
    check({tag, "_ld0"}, 64'(bus.r0_load_data), 64'(m_ld[0]));
    check({tag, "_ld1"}, 64'(bus.r1_load_data), 64'(m_ld[1]));
    check({tag, "_da0"}, 64'(bus.r0_data_addr), 64'(m_da[0]));
    check({tag, "_da1"}, 64'(bus.r1_data_addr), 64'(m_da[1]));
  endtask

  task automatic clear_requests();
    bus.r0_load = 1'b0; bus.r0_store = 1'b0;
    bus.r1_load = 1'b0; bus.r1_store = 1'b0;
  endtask

  // op: 0 none, 1 load, 2 store, 3 load+store (load wins)
  task automatic txn(input int op0, input int op1,
                     input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                     input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                     input int stall, input int delay, input logic [DW-1:0] rdata,
                     input bit noisy_valid);
    int w;
    int opw;
    bit ld;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    bus.r0_load  = (op0 == 1) || (op0 == 3);
    bus.r0_store = (op0 == 2) || (op0 == 3);
    bus.r0_address = a0; bus.r0_store_data = d0;
    bus.r1_load  = (op1 == 1) || (op1 == 3);
    bus.r1_store = (op1 == 2) || (op1 == 3);
    bus.r1_address = a1; bus.r1_store_data = d1;
    bus.d_mem_ready = 1'b0;
    bus.d_mem_valid = 1'b0;
    if (op0 != 0 && op1 != 0) w = RR ? pref : 0;
    else w = (op1 != 0) ? 1 : 0;
    if (RR) pref = 1 - w;
    opw = (w == 1) ? op1 : op0;
    ld  = (opw != 2);
    ea  = (w == 1) ? a1 : a0;
    ed  = (w == 1) ? d1 : d0;

    @(negedge clock);
    check("grant_ready0", 64'(bus.r0_ready), 64'(w == 0));
    check("grant_ready1", 64'(bus.r1_ready), 64'(w == 1));
    check("issue_valid0", 64'(bus.r0_valid), 64'd0);
    check("issue_valid1", 64'(bus.r1_valid), 64'd0);
    if (w == 0) begin bus.r0_load = 1'b0; bus.r0_store = 1'b0; end
    else        begin bus.r1_load = 1'b0; bus.r1_store = 1'b0; end

    for (int i = 0; i <= stall; i++) begin
      check("issue_read",  64'(bus.d_mem_read),    64'(ld));
      check("issue_write", 64'(bus.d_mem_write),   64'(!ld));
      check("issue_addr",  64'(bus.d_mem_address), 64'(ea));
      check("issue_data",  64'(bus.d_mem_in_data), 64'(ed));
      if (i > 0) begin
        check("stall_ready0", 64'(bus.r0_ready), 64'd0);
        check("stall_ready1", 64'(bus.r1_ready), 64'd0);
      end
      bus.d_mem_ready = (i == stall);
      bus.d_mem_valid = noisy_valid ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.d_mem_out_data = $urandom;
      bus.d_mem_out_addr = AW'($urandom);
      @(negedge clock);
    end
    bus.d_mem_ready = 1'b0;
    bus.d_mem_valid = 1'b0;
    check("post_read",  64'(bus.d_mem_read),  64'd0);
    check("post_write", 64'(bus.d_mem_write), 64'd0);
    check("post_valid0", 64'(bus.r0_valid), 64'd0);
    check("post_valid1", 64'(bus.r1_valid), 64'd0);

    if (ld) begin
      for (int i = 0; i < delay; i++) begin
        @(negedge clock);
        check("wait_valid0", 64'(bus.r0_valid), 64'd0);
        check("wait_valid1", 64'(bus.r1_valid), 64'd0);
      end
      bus.d_mem_valid    = 1'b1;
      bus.d_mem_out_data = rdata;
      bus.d_mem_out_addr = ea;
      @(negedge clock);
      bus.d_mem_valid = 1'b0;
      m_ld[w] = rdata;
      m_da[w] = ea;
      check("resp_valid0", 64'(bus.r0_valid), 64'(w == 0));
      check("resp_valid1", 64'(bus.r1_valid), 64'(w == 1));
      check_responses("resp");
    end else begin
      check_responses("store");
    end
    clear_requests();
  endtask

  initial begin
    int op0;
    int op1;
    checks = 0;
    failures = 0;
    model_reset();
    reset = 1'b1;
    report = 1'b0;
    clear_requests();
    bus.r0_address = '0; bus.r0_store_data = '0;
    bus.r1_address = '0; bus.r1_store_data = '0;
    bus.d_mem_out_addr = '0; bus.d_mem_out_data = '0;
    bus.d_mem_valid = 1'b0; bus.d_mem_ready = 1'b0;

    // Reset state
    #12;
    check("rst_ready0", 64'(bus.r0_ready), 64'd0);
    check("rst_ready1", 64'(bus.r1_ready), 64'd0);
    check("rst_valid0", 64'(bus.r0_valid), 64'd0);
    check("rst_valid1", 64'(bus.r1_valid), 64'd0);
    check("rst_read",   64'(bus.d_mem_read),  64'd0);
    check("rst_write",  64'(bus.d_mem_write), 64'd0);
    check("rst_addr",   64'(bus.d_mem_address), 64'd0);
    check("rst_data",   64'(bus.d_mem_in_data), 64'd0);
    check_responses("rst");

    @(negedge clock);
    reset = 1'b0;

    // Store from requester 0 accepted immediately
    txn(2, 0, 20'h00010, 20'h0, 32'hDEADBEEF, 32'h0, 0, 0, 32'h0, 1'b0);
    // Load from requester 1 answered two cycles after the request
    txn(0, 1, 20'h0, 20'h00020, 32'h0, 32'h0, 0, 0, 32'h12345678, 1'b0);
    // Memory stalls five cycles in ISSUE
    txn(1, 0, 20'h00abc, 20'h0, 32'h0, 32'h0, 5, 1, 32'hA5A5A5A5, 1'b0);
    // Load+store on one requester latches a load
    txn(3, 0, 20'hFFFFF, 20'h0, 32'hFFFFFFFF, 32'h0, 0, 2, 32'h0BADF00D, 1'b0);

    // Spurious memory valid while idle
    bus.d_mem_valid = 1'b1;
    bus.d_mem_out_data = 32'hCAFEBABE;
    bus.d_mem_out_addr = 20'h12345;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("idle_valid0", 64'(bus.r0_valid), 64'd0);
      check("idle_valid1", 64'(bus.r1_valid), 64'd0);
      check("idle_read",   64'(bus.d_mem_read), 64'd0);
      check("idle_write",  64'(bus.d_mem_write), 64'd0);
    end
    check_responses("idle");
    bus.d_mem_valid = 1'b0;

    // Both requesters load continuously for four grants
    for (int g = 0; g < 4; g++) begin
      txn(1, 1, AW'(20'h00100 + g), AW'(20'h00200 + g), 32'h0, 32'h0,
          0, 0, 32'h1000_0000 + g, 1'b0);
    end

    // Reset while waiting for a load response, then a late memory valid
    bus.r0_load = 1'b1; bus.r0_address = 20'h00777;
    @(negedge clock);
    clear_requests();
    bus.d_mem_ready = 1'b1;
    @(negedge clock);
    bus.d_mem_ready = 1'b0;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("async_rst_read", 64'(bus.d_mem_read), 64'd0);
    check_responses("async_rst");
    @(negedge clock);
    reset = 1'b0;
    bus.d_mem_valid = 1'b1;
    bus.d_mem_out_data = 32'h55AA55AA;
    bus.d_mem_out_addr = 20'h00777;
    @(negedge clock);
    bus.d_mem_valid = 1'b0;
    check("abort_valid0", 64'(bus.r0_valid), 64'd0);
    check("abort_valid1", 64'(bus.r1_valid), 64'd0);
    check("abort_read",   64'(bus.d_mem_read), 64'd0);
    check("abort_addr",   64'(bus.d_mem_address), 64'd0);
    check_responses("abort");

    // Randomized transactions
    for (int n = 0; n < 60; n++) begin
      op0 = $urandom_range(0, 3);
      op1 = $urandom_range(0, 3);
      if (op0 == 0 && op1 == 0) op1 = 1 + $urandom_range(0, 2);
      txn(op0, op1, AW'($urandom), AW'($urandom), $urandom, $urandom,
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
